inscache: RTL and testbench

- Direct-mapped, read-only instruction cache that answers the fetch unit's PC requests.
- On a hit, it returns the 32-bit instruction window at a halfword-aligned PC in the same cycle.
- On a miss, it refills whole 16-byte lines from the memory controller, one word per handshake.
- It supports RVC: a 32-bit instruction may straddle two lines.

---
 rtl/inscache_if.sv | 22 ++
 rtl/inscache.sv | 157 +++++++++++++++
 tb/tb_inscache.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inscache_if.sv
// Fetch-side and memory-controller-side signals of the instruction cache.
// The cache uses the slave modport; the fetch unit and memory controller use master.
interface inscache_if;
    logic [31:0] if_pc;
    logic        if_ask;
    logic        if_give;
    logic [31:0] if_ins;
    logic        mc_req;
    logic [31:0] mc_addr;
    logic        mc_done;
    logic [31:0] mc_data;

    modport slave (
        input  if_pc, if_ask, mc_done, mc_data,
        output if_give, if_ins, mc_req, mc_addr
    );

    modport master (
        output if_pc, if_ask, mc_done, mc_data,
        input  if_give, if_ins, mc_req, mc_addr
    );
endinterface

// File: rtl/inscache.sv
// Direct-mapped read-only instruction cache with 16-byte lines and RVC straddle support.
// Hits answer combinationally; misses refill a whole line one word per handshake.
module inscache #(
    parameter int INDEX_BITS = 6
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rdy_in,
    inscache_if.slave  bus
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 28 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    state_t                state_q, state_d;
    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_q   [LINES];
    logic [31:0]           data_q  [LINES][4];
    logic [31:0]           line_buf_q [4];
    logic [27:0]           fill_line_q, fill_line_d;
    logic [1:0]            cnt_q;
    logic                  mc_req_q;
    logic [31:0]           mc_addr_q;

    logic                  start_fill, take_word, install, reissue;

    logic [31:0]           pc, pc_hi;
    logic [INDEX_BITS-1:0] lo_idx, hi_idx, fill_idx, start_idx;
    logic [TAG_BITS-1:0]   lo_tag, hi_tag;
    logic [31:0]           lo_word, hi_word;
    logic [15:0]           lo_hw, hi_hw;
    logic                  lo_hit, hi_hit, compressed;
    logic                  unused_pc_lsb;

    assign pc            = bus.if_pc;
    assign pc_hi         = pc + 32'd2;
    assign unused_pc_lsb = pc[0] ^ pc_hi[0];

    assign lo_idx = pc[4+INDEX_BITS-1:4];
    assign lo_tag = pc[31:4+INDEX_BITS];
    assign hi_idx = pc_hi[4+INDEX_BITS-1:4];
    assign hi_tag = pc_hi[31:4+INDEX_BITS];

    assign lo_word = data_q[lo_idx][pc[3:2]];
    assign hi_word = data_q[hi_idx][pc_hi[3:2]];
    assign lo_hw   = pc[1]    ? lo_word[31:16] : lo_word[15:0];
    assign hi_hw   = pc_hi[1] ? hi_word[31:16] : hi_word[15:0];

    // hi_* naturally covers both the in-line case and the next-line straddle at offset 14
    assign lo_hit     = valid_q[lo_idx] && (tag_q[lo_idx] == lo_tag);
    assign hi_hit     = valid_q[hi_idx] && (tag_q[hi_idx] == hi_tag);
    assign compressed = (lo_hw[1:0] != 2'b11);

    assign bus.if_give = bus.if_ask && rdy_in && lo_hit && (compressed || hi_hit);
    assign bus.if_ins  = !bus.if_give ? 32'h0 :
                         compressed   ? {16'h0, lo_hw} : {hi_hw, lo_hw};

    assign bus.mc_req  = mc_req_q;
    assign bus.mc_addr = mc_addr_q;

    assign fill_idx  = fill_line_q[INDEX_BITS-1:0];
    assign start_idx = fill_line_d[INDEX_BITS-1:0];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else if (rdy_in) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fill_line_d = fill_line_q;
        start_fill  = 1'b0;
        take_word   = 1'b0;
        install     = 1'b0;
        reissue     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.if_ask && !lo_hit) begin
                    state_d     = REQ;
                    fill_line_d = pc[31:4];
                    start_fill  = 1'b1;
                end else if (bus.if_ask && !compressed && (pc[3:0] == 4'hE) && !hi_hit) begin
                    state_d     = REQ;
                    fill_line_d = pc[31:4] + 28'd1;
                    start_fill  = 1'b1;
                end
            end
            REQ: begin
                if (bus.mc_done) begin
                    take_word = 1'b1;
                    if (cnt_q == 2'd3) begin
                        install = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                reissue = 1'b1;
                state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q     <= '0;
            cnt_q       <= 2'd0;
            mc_req_q    <= 1'b0;
            mc_addr_q   <= 32'h0;
            fill_line_q <= 28'h0;
        end else if (rdy_in) begin
            fill_line_q <= fill_line_d;
            // the target line stops hitting as soon as its refill begins
            if (start_fill) begin
                valid_q[start_idx] <= 1'b0;
                mc_req_q           <= 1'b1;
                mc_addr_q          <= {fill_line_d, 4'h0};
                cnt_q              <= 2'd0;
            end
            if (take_word) begin
                mc_req_q <= 1'b0;
                if (install) begin
                    valid_q[fill_idx] <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 2'd1;
                end
            end
            if (reissue) begin
                mc_req_q  <= 1'b1;
                mc_addr_q <= {fill_line_q, cnt_q, 2'b00};
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in) begin
            if (take_word) begin
                line_buf_q[cnt_q] <= bus.mc_data;
            end
            // the last word is taken straight from the bus so the line hits next cycle
            if (install) begin
                tag_q[fill_idx]     <= fill_line_q[27:INDEX_BITS];
                data_q[fill_idx][0] <= line_buf_q[0];
                data_q[fill_idx][1] <= line_buf_q[1];
                data_q[fill_idx][2] <= line_buf_q[2];
                data_q[fill_idx][3] <= bus.mc_data;
            end
        end
    end
endmodule

// File: tb/tb_inscache.sv
// Bench for inscache: directed fills and lookup table, then random fetches
// checked against an address-level cache model over an immutable memory image.
module tb_inscache;
    logic clk = 1'b0;
    logic rst;
    logic rdy;

    inscache_if bus();

    inscache #(.INDEX_BITS(6)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_ovr [logic [31:0]];
    logic        mem_auto  = 1'b0;
    logic        man_done  = 1'b0;
    logic        auto_done = 1'b0;
    logic [31:0] man_data  = 32'h0;
    logic [31:0] auto_data = 32'h0;

    assign bus.mc_done = mem_auto ? auto_done : man_done;
    assign bus.mc_data = mem_auto ? auto_data : man_data;

    // model: which 28-bit line address sits in each of the 64 slots
    bit          m_valid [64];
    logic [27:0] m_line  [64];
    bit          m_fill;
    logic [27:0] m_base;
    int          m_words;

    typedef struct {
        logic [31:0] pc;
        bit          ask;
        bit          rd;
        bit          give;
        logic [31:0] ins;
    } vec_t;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w = {a[31:2], 2'b00};
        if (mem_ovr.exists(w)) return mem_ovr[w];
        return (w * 32'h9E3779B1) ^ (w >> 7) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [15:0] mem_hw(input logic [31:0] a);
        logic [31:0] w = mem_word(a);
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic bit present(input logic [27:0] line);
        return m_valid[line[5:0]] && (m_line[line[5:0]] == line);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic ref_out(input logic [31:0] pc, input bit ask, input bit rd,
                           output bit g, output logic [31:0] ins);
        logic [31:0] pc2 = pc + 32'd2;
        logic [15:0] lo  = mem_hw(pc);
        logic [15:0] hi  = mem_hw(pc2);
        bit          c   = (lo[1:0] != 2'b11);
        g   = ask && rd && present(pc[31:4]) && (c || present(pc2[31:4]));
        ins = !g ? 32'h0 : (c ? {16'h0, lo} : {hi, lo});
    endtask

    task automatic model_start(input logic [27:0] line);
        m_base             = line;
        m_valid[line[5:0]] = 1'b0;
        m_fill             = 1'b1;
        m_words            = 0;
    endtask

    task automatic model_step();
        logic [31:0] pc = bus.if_pc;
        logic [15:0] lo = mem_hw(pc);
        if (rst) begin
            for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
            m_fill  = 1'b0;
            m_words = 0;
        end else if (rdy) begin
            if (!m_fill) begin
                if (bus.if_ask && !present(pc[31:4]))
                    model_start(pc[31:4]);
                else if (bus.if_ask && lo[1:0] == 2'b11 && pc[3:0] == 4'hE &&
                         !present(pc[31:4] + 28'd1))
                    model_start(pc[31:4] + 28'd1);
            end else if (bus.mc_done) begin
                m_words++;
                if (m_words == 4) begin
                    m_valid[m_base[5:0]] = 1'b1;
                    m_line[m_base[5:0]]  = m_base;
                    m_fill               = 1'b0;
                end
            end
        end
    endtask

    // Drives n words of a fill by hand, checking address, the single idle gap, and timeout.
    task automatic fill_expect(input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            int waited = 0;
            while (!bus.mc_req && waited < 40) begin
                @(negedge clk);
                waited++;
            end
            chk("fill_req", {31'b0, bus.mc_req}, 32'd1);
            chk("fill_addr", bus.mc_addr, base + 32'(4 * k));
            man_data = mem_word(base + 32'(4 * k));
            man_done = 1'b1;
            @(negedge clk);
            man_done = 1'b0;
            chk("fill_gap", {31'b0, bus.mc_req}, 32'd0);
            if (k < 3) begin
                @(negedge clk);
                chk("gap_len", {31'b0, bus.mc_req}, 32'd1);
            end
        end
    endtask

    function automatic logic [31:0] rand_pc();
        int unsigned r = $urandom_range(0, 19);
        logic [27:0] line;
        logic [2:0]  h = 3'($urandom_range(0, 7));
        if (r < 8)       line = 28'(r);
        else if (r < 16) line = 28'(64 + r - 8);
        else if (r < 19) line = 28'hFFF_FFFF;
        else             line = 28'd128;
        return {line, h, 1'b0};
    endfunction

    initial begin : mem_proc
        int wait_n = 0;
        forever begin
            @(negedge clk);
            if (mem_auto) begin
                if (auto_done) begin
                    auto_done = 1'b0;
                end else if (bus.mc_req) begin
                    if (wait_n == 0) begin
                        chk("mem_busy", {31'b0, m_fill}, 32'd1);
                        chk("mem_addr", bus.mc_addr, {m_base, 4'h0} + 32'(m_words * 4));
                        auto_data = mem_word(bus.mc_addr);
                        auto_done = 1'b1;
                        wait_n    = int'($urandom_range(0, 2));
                    end else begin
                        wait_n--;
                    end
                end
            end
        end
    end

    initial begin
        vec_t        vecs [12];
        bit          g;
        logic [31:0] ins;

        mem_ovr[32'h0]   = 32'h0010_0093;
        mem_ovr[32'h4]   = 32'h0020_0113;
        mem_ovr[32'h8]   = 32'h0030_0193;
        mem_ovr[32'hC]   = 32'h4505_0000;
        mem_ovr[32'h10]  = 32'h1234_0FF0;
        mem_ovr[32'h20]  = 32'h0070_0393;
        mem_ovr[32'h400] = 32'h0050_0293;

        vecs[0]  = '{32'h0,        1'b1, 1'b1, 1'b1, 32'h0010_0093};
        vecs[1]  = '{32'h2,        1'b1, 1'b1, 1'b1, 32'h0000_0010};
        vecs[2]  = '{32'h4,        1'b1, 1'b1, 1'b1, 32'h0020_0113};
        vecs[3]  = '{32'h6,        1'b1, 1'b1, 1'b1, 32'h0000_0020};
        vecs[4]  = '{32'h8,        1'b1, 1'b1, 1'b1, 32'h0030_0193};
        vecs[5]  = '{32'hA,        1'b1, 1'b1, 1'b1, 32'h0000_0030};
        vecs[6]  = '{32'hE,        1'b1, 1'b1, 1'b1, 32'h0000_4505};
        vecs[7]  = '{32'h4,        1'b0, 1'b1, 1'b0, 32'h0};
        vecs[8]  = '{32'h4,        1'b1, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{32'h10,       1'b1, 1'b1, 1'b0, 32'h0};
        vecs[10] = '{32'h400,      1'b1, 1'b1, 1'b0, 32'h0};
        vecs[11] = '{32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0, 32'h0};

        rst        = 1'b1;
        rdy        = 1'b1;
        bus.if_ask = 1'b0;
        bus.if_pc  = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_give", {31'b0, bus.if_give}, 32'd0);
        chk("rst_req", {31'b0, bus.mc_req}, 32'd0);
        chk("rst_addr", bus.mc_addr, 32'h0);

        // cold miss at 0x0
        rst        = 1'b0;
        bus.if_ask = 1'b1;
        bus.if_pc  = 32'h0;
        #1;
        chk("cold_give", {31'b0, bus.if_give}, 32'd0);
        fill_expect(32'h0, 4);
        chk("cold_hit_give", {31'b0, bus.if_give}, 32'd1);
        chk("cold_hit_ins", bus.if_ins, 32'h0010_0093);

        bus.if_pc = 32'h4;
        #1;
        chk("hit_give", {31'b0, bus.if_give}, 32'd1);
        chk("hit_ins", bus.if_ins, 32'h0020_0113);
        @(negedge clk);
        chk("hit_noreq", {31'b0, bus.mc_req}, 32'd0);

        bus.if_ask = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.if_pc  = vecs[i].pc;
            bus.if_ask = vecs[i].ask;
            rdy        = vecs[i].rd;
            #1;
            chk($sformatf("vec%0d_give", i), {31'b0, bus.if_give}, {31'b0, vecs[i].give});
            chk($sformatf("vec%0d_ins", i), bus.if_ins, vecs[i].ins);
            bus.if_ask = 1'b0;
            rdy        = 1'b1;
        end

        // compressed instruction in the last halfword must not pull in the next line
        @(negedge clk);
        bus.if_pc  = 32'hE;
        bus.if_ask = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("c_end_give", {31'b0, bus.if_give}, 32'd1);
            chk("c_end_noreq", {31'b0, bus.mc_req}, 32'd0);
        end

        // conflict at index 0 evicts line 0x0
        bus.if_pc = 32'h400;
        fill_expect(32'h400, 4);
        chk("evict_ins", bus.if_ins, 32'h0050_0293);
        mem_ovr[32'hC] = 32'h0513_0000;
        bus.if_pc = 32'h0;
        #1;
        chk("evict_miss", {31'b0, bus.if_give}, 32'd0);
        fill_expect(32'h0, 4);

        // 32-bit instruction straddling lines 0x0 and 0x10
        bus.if_pc = 32'hE;
        #1;
        chk("straddle_wait", {31'b0, bus.if_give}, 32'd0);
        fill_expect(32'h10, 4);
        chk("straddle_give", {31'b0, bus.if_give}, 32'd1);
        chk("straddle_ins", bus.if_ins, 32'h0FF0_0513);

        // rdy low freezes the fill and ignores a done pulse
        bus.if_pc = 32'h20;
        begin
            int waited = 0;
            while (!bus.mc_req && waited < 40) begin
                @(negedge clk);
                waited++;
            end
        end
        chk("frz_start_addr", bus.mc_addr, 32'h20);
        rdy       = 1'b0;
        bus.if_pc = 32'h0;
        man_data  = 32'hDEAD_BEEF;
        man_done  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("frz_req", {31'b0, bus.mc_req}, 32'd1);
            chk("frz_addr", bus.mc_addr, 32'h20);
            chk("frz_give", {31'b0, bus.if_give}, 32'd0);
        end
        man_done  = 1'b0;
        rdy       = 1'b1;
        bus.if_pc = 32'h20;
        fill_expect(32'h20, 4);
        chk("frz_ins", bus.if_ins, 32'h0070_0393);

        // reset in the middle of a fill
        bus.if_pc = 32'h30;
        fill_expect(32'h30, 2);
        rst       = 1'b1;
        bus.if_pc = 32'h0;
        @(negedge clk);
        chk("mid_rst_req", {31'b0, bus.mc_req}, 32'd0);
        chk("mid_rst_addr", bus.mc_addr, 32'h0);
        rst = 1'b0;
        #1;
        chk("mid_rst_miss", {31'b0, bus.if_give}, 32'd0);
        fill_expect(32'h0, 4);
        chk("mid_rst_ins", bus.if_ins, 32'h0010_0093);

        // random fetches against the model
        rst        = 1'b1;
        bus.if_ask = 1'b0;
        mem_auto   = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            model_step();
            #1;
            rst = ($urandom_range(0, 299) == 0);
            rdy = ($urandom_range(0, 9) != 0);
            bus.if_ask = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 1) == 0) bus.if_pc = rand_pc();
            @(negedge clk);
            ref_out(bus.if_pc, bus.if_ask, rdy, g, ins);
            chk("rand_give", {31'b0, bus.if_give}, {31'b0, g});
            chk("rand_ins", bus.if_ins, ins);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
